// File: rtl/adler32_ctrl.sv
// Byte-to-word sequencer for the adler32 engine: packs bytes big-endian into
// 32-bit words, handshakes each word, then streams the checksum as a zlib trailer.
module adler32_ctrl #(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned NUM_WD  = 2,
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               s_val_i,
  input  logic [7:0]         s_dat_i,
  input  logic               s_lst_i,
  output logic               s_rdy_o,
  output logic               a_start_o,
  output logic               a_val_o,
  output logic [DATA_WD-1:0] a_dat_o,
  output logic [NUM_WD-1:0]  a_num_o,
  output logic               a_lst_o,
  input  logic               a_val_i,
  input  logic               a_done_i,
  input  logic [DATA_WD-1:0] a_dat_i,
  output logic               m_val_o,
  output logic [7:0]         m_dat_o,
  output logic               m_lst_o,
  input  logic               m_rdy_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [DATA_WD-1:0] cks_o
);

  localparam int unsigned BYTES  = DATA_WD / 8;
  localparam int unsigned TMO_WD = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    PACK  = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    TRAIL = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t              state, state_d;
  logic [NUM_WD-1:0]   cnt, cnt_d;
  logic [1:0]          tidx, tidx_d;
  logic [TMO_WD-1:0]   wdog, wdog_d;
  logic [DATA_WD-1:0]  pack_d, cks_d;
  logic [NUM_WD-1:0]   num_d;
  logic                lst_d, err_d;
  logic [7:0]          m_dat_d;

  // Next state plus next values of every registered output.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    tidx_d  = tidx;
    wdog_d  = wdog;
    pack_d  = a_dat_o;
    num_d   = a_num_o;
    lst_d   = a_lst_o;
    cks_d   = cks_o;
    err_d   = err_o;
    m_dat_d = 8'h00;

    case (state)
      IDLE: begin
        if (start_i) begin
          err_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        pack_d  = '0;
        state_d = PACK;
      end
      PACK: begin
        if (s_val_i) begin
          for (int unsigned k = 0; k < BYTES; k++) begin
            if (cnt == NUM_WD'(k)) pack_d[DATA_WD-1-8*k -: 8] = s_dat_i;
          end
          cnt_d = cnt + NUM_WD'(1);
          if (cnt == NUM_WD'(BYTES-1) || s_lst_i) begin
            num_d   = cnt;
            lst_d   = s_lst_i;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog + TMO_WD'(1);
        // The awaited acknowledge depends on whether this was the final word.
        if (!a_lst_o && a_val_i) begin
          cnt_d   = '0;
          pack_d  = '0;
          state_d = PACK;
        end else if (a_lst_o && a_done_i) begin
          cks_d   = a_dat_i;
          tidx_d  = 2'd0;
          state_d = TRAIL;
        end else if (wdog == TMO_WD'(TMO_CYC-1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      TRAIL: begin
        if (m_rdy_i) begin
          if (tidx == 2'd3) state_d = DONE;
          else              tidx_d  = tidx + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    for (int unsigned k = 0; k < BYTES; k++) begin
      if (state_d == TRAIL && tidx_d == 2'(k)) m_dat_d = cks_d[DATA_WD-1-8*k -: 8];
    end
  end

  // State and output registers; outputs decode the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tidx      <= 2'd0;
      wdog      <= '0;
      s_rdy_o   <= 1'b0;
      a_start_o <= 1'b0;
      a_val_o   <= 1'b0;
      a_dat_o   <= '0;
      a_num_o   <= '0;
      a_lst_o   <= 1'b0;
      m_val_o   <= 1'b0;
      m_dat_o   <= 8'h00;
      m_lst_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      cks_o     <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      tidx      <= tidx_d;
      wdog      <= wdog_d;
      s_rdy_o   <= (state_d == PACK);
      a_start_o <= (state_d == START);
      a_val_o   <= (state_d == ISSUE);
      a_dat_o   <= pack_d;
      a_num_o   <= num_d;
      a_lst_o   <= lst_d;
      m_val_o   <= (state_d == TRAIL);
      m_dat_o   <= m_dat_d;
      m_lst_o   <= (state_d == TRAIL) && (tidx_d == 2'd3);
      busy_o    <= (state_d != IDLE);
      done_o    <= (state_d == DONE);
      err_o     <= err_d;
      cks_o     <= cks_d;
    end
  end

endmodule

// File: tb/tb_adler32_ctrl.sv
// Randomized bench for adler32_ctrl: an engine model answers each word, and a
// stream-level reference model predicts words, trailer and checksum.
module tb_adler32_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned NW  = 2;
  localparam int unsigned TMO = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  num;
    logic        lst;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, s_val_i, s_lst_i, s_rdy_o;
  logic [7:0]    s_dat_i;
  logic          a_start_o, a_val_o, a_lst_o, a_val_i, a_done_i;
  logic [DW-1:0] a_dat_o, a_dat_i, cks_o;
  logic [NW-1:0] a_num_o;
  logic          m_val_o, m_lst_o, m_rdy_i, busy_o, done_o, err_o;
  logic [7:0]    m_dat_o;

  adler32_ctrl #(.DATA_WD(DW), .NUM_WD(NW), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .s_val_i(s_val_i), .s_dat_i(s_dat_i), .s_lst_i(s_lst_i), .s_rdy_o(s_rdy_o),
    .a_start_o(a_start_o), .a_val_o(a_val_o), .a_dat_o(a_dat_o), .a_num_o(a_num_o),
    .a_lst_o(a_lst_o), .a_val_i(a_val_i), .a_done_i(a_done_i), .a_dat_i(a_dat_i),
    .m_val_o(m_val_o), .m_dat_o(m_dat_o), .m_lst_o(m_lst_o), .m_rdy_i(m_rdy_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .cks_o(cks_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bq_t         src;
  word_t       exp_w[$];
  logic [7:0]  exp_t[$];
  logic [31:0] exp_cks;
  int          trail_seen, done_cnt, m_cycles, rmode, stall_left;
  logic        xfer, prev_hold;
  logic [7:0]  prev_dat;
  int          eng_lat;
  logic        eng_mute;

  function automatic logic [31:0] adler(input bq_t q);
    int unsigned a, b;
    a = 1;
    b = 0;
    foreach (q[i]) begin
      a = (a + 32'(q[i])) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got none want event", nm);
  endtask

  task automatic set_src(input string s);
    src.delete();
    for (int i = 0; i < s.len(); i++) src.push_back(8'(s[i]));
  endtask

  // Reference model: chop the stream into big-endian words, then a big-endian trailer.
  task automatic build_model();
    exp_w.delete();
    exp_t.delete();
    for (int i = 0; i < src.size(); i += 4) begin
      word_t w;
      int    n;
      n = (src.size() - i >= 4) ? 4 : src.size() - i;
      w.dat = '0;
      for (int j = 0; j < n; j++) w.dat[31-8*j -: 8] = src[i+j];
      w.num = 2'(n - 1);
      w.lst = (i + 4 >= src.size());
      exp_w.push_back(w);
    end
    exp_cks = adler(src);
    for (int j = 0; j < 4; j++) exp_t.push_back(exp_cks[31-8*j -: 8]);
    trail_seen = 0;
    prev_hold  = 1'b0;
  endtask

  // One clock: compare outputs at the falling edge, then drive at posedge+1.
  task automatic tick();
    word_t      w;
    logic [7:0] b;
    @(negedge clk);
    xfer = s_val_i & s_rdy_o;
    if (!rst) begin
      if (a_val_o) begin
        if (exp_w.size() > 0) begin
          w = exp_w.pop_front();
          chk("a_dat", a_dat_o, w.dat);
          chk("a_num", 32'(a_num_o), 32'(w.num));
          chk("a_lst", 32'(a_lst_o), 32'(w.lst));
        end else fail_now("unexpected_word");
      end
      if (m_val_o) begin
        m_cycles++;
        if (prev_hold) chk("m_hold", 32'(m_dat_o), 32'(prev_dat));
        if (m_rdy_i) begin
          if (exp_t.size() > 0) begin
            b = exp_t.pop_front();
            chk("m_dat", 32'(m_dat_o), 32'(b));
            chk("m_lst", 32'(m_lst_o), 32'(exp_t.size() == 0));
          end else fail_now("unexpected_trailer_byte");
          trail_seen++;
        end
      end
      prev_hold = m_val_o & ~m_rdy_i;
      prev_dat  = m_dat_o;
      if (done_o) begin
        chk("cks", cks_o, exp_cks);
        chk("trail_cnt", 32'(trail_seen), 32'd4);
        done_cnt++;
      end
    end
    @(posedge clk);
    #1;
    case (rmode)
      0: m_rdy_i = 1'b1;
      1: m_rdy_i = 1'($urandom_range(0, 1));
      default: begin
        if (m_val_o && trail_seen == 0 && stall_left > 0) begin
          m_rdy_i = 1'b0;
          stall_left--;
        end else m_rdy_i = 1'b1;
      end
    endcase
  endtask

  // Feed src[0..cnt-1]; vmode 0 = always valid, 1 = toggling, 2 = random with stray starts.
  task automatic feed(input int vmode, input int cnt, input bit lst_en);
    int i, budget;
    i = 0;
    budget = 0;
    while (i < cnt && budget < 400) begin
      case (vmode)
        0: s_val_i = 1'b1;
        1: s_val_i = 1'(budget % 2 == 0);
        default: s_val_i = 1'($urandom_range(0, 1));
      endcase
      start_i = (vmode == 2) ? 1'($urandom_range(0, 7) == 0) : 1'b0;
      s_dat_i = s_val_i ? src[i] : 8'($urandom);
      s_lst_i = lst_en && (i == cnt - 1);
      tick();
      if (xfer) i++;
      budget++;
    end
    s_val_i = 1'b0;
    s_lst_i = 1'b0;
    start_i = 1'b0;
    if (i < cnt) fail_now("feed_timeout");
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_pulse", 32'(a_start_o), 32'd1);
    chk("start_busy", 32'(busy_o), 32'd1);
    chk("start_err_clr", 32'(err_o), 32'd0);
  endtask

  task automatic run_stream(input int vmode, input int rm, input bit use_lit,
                            input logic [31:0] lit);
    int base, b;
    build_model();
    rmode      = rm;
    stall_left = 3;
    base       = done_cnt;
    start_pulse();
    feed(vmode, src.size(), 1'b1);
    b = 0;
    while (done_cnt == base && b < 500) begin
      tick();
      b++;
    end
    if (done_cnt == base) fail_now("done_timeout");
    chk("done_pulse_once", 32'(done_cnt - base), 32'd1);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_done", 32'(done_o), 32'd0);
    chk("no_err", 32'(err_o), 32'd0);
    chk("words_left", 32'(exp_w.size()), 32'd0);
    chk("trail_left", 32'(exp_t.size()), 32'd0);
    if (use_lit) chk("cks_literal", cks_o, lit);
  endtask

  // Engine model: answers each issued word after a latency; final word gets the checksum.
  initial begin
    bq_t eng_q;
    int  lat;
    a_val_i  = 1'b0;
    a_done_i = 1'b0;
    a_dat_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      a_val_i  = 1'b0;
      a_done_i = 1'b0;
      if (rst || a_start_o) eng_q.delete();
      else if (a_val_o && !eng_mute) begin
        for (int j = 0; j <= int'(a_num_o); j++) eng_q.push_back(a_dat_o[31-8*j -: 8]);
        lat = (eng_lat > 0) ? eng_lat : int'($urandom_range(1, 5));
        repeat (lat) @(posedge clk);
        #1;
        if (a_lst_o) begin
          a_dat_i  = adler(eng_q);
          a_done_i = 1'b1;
        end else a_val_i = 1'b1;
      end
    end
  end

  initial begin
    int n, base_m, base_d;
    rst = 1'b1; start_i = 1'b0; s_val_i = 1'b0; s_dat_i = 8'h00; s_lst_i = 1'b0;
    m_rdy_i = 1'b1; rmode = 0; stall_left = 0; eng_lat = 0; eng_mute = 1'b0;
    trail_seen = 0; done_cnt = 0; m_cycles = 0; prev_hold = 1'b0; prev_dat = 8'h00;
    xfer = 1'b0; exp_cks = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ctl", 32'({s_rdy_o, a_start_o, a_val_o, a_num_o, a_lst_o, m_val_o,
                        m_lst_o, busy_o, done_o, err_o}), 32'd0);
    chk("rst_cks", cks_o, 32'd0);

    set_src("Wikipedia");
    chk("model_wiki", adler(src), 32'h11E60398);
    set_src("abcd");
    chk("model_abcd", adler(src), 32'h03D8018B);

    eng_lat = 3;
    set_src("a");
    run_stream(0, 0, 1'b1, 32'h00620062);
    eng_lat = 0;
    set_src("Wikipedia");
    run_stream(0, 0, 1'b1, 32'h11E60398);
    set_src("abc");
    run_stream(1, 0, 1'b1, 32'h024D0127);
    set_src("abcd");
    run_stream(0, 2, 1'b1, 32'h03D8018B);

    // Engine stall: watchdog aborts with a sticky error and no trailer.
    eng_mute = 1'b1;
    set_src("ab");
    build_model();
    rmode  = 0;
    base_m = m_cycles;
    base_d = done_cnt;
    start_pulse();
    feed(0, src.size(), 1'b1);
    n = 0;
    while (!err_o && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd17);
    chk("tmo_busy", 32'(busy_o), 32'd0);
    tick();
    chk("tmo_err_sticky", 32'(err_o), 32'd1);
    chk("tmo_no_trailer", 32'(m_cycles - base_m), 32'd0);
    chk("tmo_no_done", 32'(done_cnt - base_d), 32'd0);
    eng_mute = 1'b0;
    set_src("xyz");
    run_stream(0, 0, 1'b0, 32'h0);

    // Reset mid-stream after two bytes.
    set_src("abc");
    build_model();
    start_pulse();
    feed(0, 2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ctl", 32'({s_rdy_o, a_start_o, a_val_o, a_num_o, a_lst_o, m_val_o,
                           m_lst_o, busy_o, done_o, err_o}), 32'd0);
    chk("midrst_adat", a_dat_o, 32'd0);
    chk("midrst_cks", cks_o, 32'd0);
    chk("midrst_mdat", 32'(m_dat_o), 32'd0);
    set_src("a");
    run_stream(0, 0, 1'b1, 32'h00620062);

    for (int t = 0; t < 25; t++) begin
      int len;
      len = int'($urandom_range(1, 13));
      src.delete();
      for (int j = 0; j < len; j++) src.push_back(8'($urandom));
      run_stream(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
